// File: rtl/mem_wb_skid_reg_if.sv
// Handshake bundle between the memory-access unit (master) and the MEM/WB skid register (slave).
// Carries the upstream entry fields, the write-back head fields and the occupancy report.
interface mem_wb_skid_reg_if #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 30,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_OP_W  = 2,
    parameter int EXP_W      = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PC_W-1:0]       in_pc;
    logic                  in_en;
    logic                  in_br_flag;
    logic [CTRL_OP_W-1:0]  in_ctrl_op;
    logic [REG_ADDR_W-1:0] in_dst_addr;
    logic                  in_gpr_we_;
    logic [EXP_W-1:0]      in_exp_code;
    logic [DATA_W-1:0]     in_out;
    logic                  in_miss_align;

    logic                  out_valid;
    logic                  out_ready;
    logic [PC_W-1:0]       mem_pc;
    logic                  mem_en;
    logic                  mem_br_flag;
    logic [CTRL_OP_W-1:0]  mem_ctrl_op;
    logic [REG_ADDR_W-1:0] mem_dst_addr;
    logic                  mem_gpr_we_;
    logic [EXP_W-1:0]      mem_exp_code;
    logic [DATA_W-1:0]     mem_out;
    logic [1:0]            occupancy;

    modport master (
        output in_valid, in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_out, in_miss_align, out_ready,
        input  in_ready, out_valid, mem_pc, mem_en, mem_br_flag, mem_ctrl_op,
               mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_out, in_miss_align, out_ready,
        output in_ready, out_valid, mem_pc, mem_en, mem_br_flag, mem_ctrl_op,
               mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out, occupancy
    );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer and valid/ready handshake.
// in_ready is registered, so write-back back-pressure never reaches upstream combinationally.
module mem_wb_skid_reg #(
    parameter int DATA_W          = 32,
    parameter int PC_W            = 30,
    parameter int REG_ADDR_W      = 5,
    parameter int CTRL_OP_W       = 2,
    parameter int EXP_W           = 3,
    parameter int MISS_ALIGN_CODE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    mem_wb_skid_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic                  en;
        logic                  br_flag;
        logic [CTRL_OP_W-1:0]  ctrl_op;
        logic [REG_ADDR_W-1:0] dst_addr;
        logic                  gpr_we_;
        logic [EXP_W-1:0]      exp_code;
        logic [DATA_W-1:0]     out;
    } entry_t;

    function automatic entry_t bubble();
        entry_t b;
        b         = '0;
        b.gpr_we_ = 1'b1;
        return b;
    endfunction

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t captured;
    logic   in_ready_q;
    logic   out_valid;
    logic   push;
    logic   pop;

    assign out_valid = (state != EMPTY);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // A misaligned access keeps pc/en/br_flag for trap handling and neutralises everything else.
    // NOTE: every field gets a value on every path of this always_comb, so no latch is inferred.
    always_comb begin
        captured.pc      = bus.in_pc;
        captured.en      = bus.in_en;
        captured.br_flag = bus.in_br_flag;
        if (bus.in_miss_align) begin
            captured.ctrl_op  = '0;
            captured.dst_addr = '0;
            captured.gpr_we_  = 1'b1;
            captured.exp_code = EXP_W'(MISS_ALIGN_CODE);
            captured.out      = '0;
        end else begin
            captured.ctrl_op  = bus.in_ctrl_op;
            captured.dst_addr = bus.in_dst_addr;
            captured.gpr_we_  = bus.in_gpr_we_;
            captured.exp_code = bus.in_exp_code;
            captured.out      = bus.in_out;
        end
    end

    // NOTE: the payload registers are reset as well, because mem_* must show the bubble out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_q     <= bubble();
            skid_q     <= bubble();
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            main_q     <= bubble();
            skid_q     <= bubble();
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= captured;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= captured;
                    end else if (push) begin
                        skid_q     <= captured;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        main_q <= bubble();
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        skid_q     <= bubble();
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_q     <= bubble();
                    skid_q     <= bubble();
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid;
    assign bus.occupancy    = state;
    assign bus.mem_pc       = main_q.pc;
    assign bus.mem_en       = main_q.en;
    assign bus.mem_br_flag  = main_q.br_flag;
    assign bus.mem_ctrl_op  = main_q.ctrl_op;
    assign bus.mem_dst_addr = main_q.dst_addr;
    assign bus.mem_gpr_we_  = main_q.gpr_we_;
    assign bus.mem_exp_code = main_q.exp_code;
    assign bus.mem_out      = main_q.out;
endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: reset, streaming, back-pressure, miss-align, flush,
// simultaneous push/pop and mid-stream reset, all with hand-computed expectations.
module tb_mem_wb_skid_reg;
    logic clk;
    logic reset;
    logic flush;
    int   n_cmp;
    int   n_bad;

    mem_wb_skid_reg_if #(
        .DATA_W(32), .PC_W(30), .REG_ADDR_W(5), .CTRL_OP_W(2), .EXP_W(3)
    ) bus ();

    mem_wb_skid_reg #(
        .DATA_W(32), .PC_W(30), .REG_ADDR_W(5), .CTRL_OP_W(2), .EXP_W(3),
        .MISS_ALIGN_CODE(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [29:0] pc, input logic [4:0] dst,
                         input logic [31:0] data);
        bus.in_valid    = valid;
        bus.in_pc       = pc;
        bus.in_en       = 1'b1;
        bus.in_br_flag  = 1'b0;
        bus.in_ctrl_op  = 2'd1;
        bus.in_dst_addr = dst;
        bus.in_gpr_we_  = 1'b0;
        bus.in_exp_code = 3'd0;
        bus.in_out      = data;
        bus.in_miss_align = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_occ"}, 32'(bus.occupancy), 32'd0);
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_we"}, 32'(bus.mem_gpr_we_), 32'd1);
        check({tag, "_exp"}, 32'(bus.mem_exp_code), 32'd0);
        check({tag, "_out"}, bus.mem_out, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 30'd0, 5'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check_empty("reset");

        // Streaming with write-back always ready: one cycle latency, occupancy never above 1.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 30'(i), 5'(i), 32'h100 + 32'(i));
            step();
            check($sformatf("stream%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("stream%0d_out", i), bus.mem_out, 32'h100 + 32'(i));
            check($sformatf("stream%0d_dst", i), 32'(bus.mem_dst_addr), 32'(i));
            check($sformatf("stream%0d_occ", i), 32'(bus.occupancy), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check_empty("stream_drain");

        // Back-pressure: A, B fill the buffer, C waits until space frees up.
        bus.out_ready = 1'b0;
        drive(1'b1, 30'h1, 5'd1, 32'hA);
        step();
        check("bp_a_occ", 32'(bus.occupancy), 32'd1);
        check("bp_a_out", bus.mem_out, 32'hA);
        drive(1'b1, 30'h2, 5'd2, 32'hB);
        step();
        check("bp_b_occ", 32'(bus.occupancy), 32'd2);
        check("bp_b_rdy", 32'(bus.in_ready), 32'd0);
        check("bp_b_head", bus.mem_out, 32'hA);
        drive(1'b1, 30'h3, 5'd3, 32'hC);
        step();
        check("bp_hold_occ", 32'(bus.occupancy), 32'd2);
        check("bp_hold_head", bus.mem_out, 32'hA);
        check("bp_hold_dst", 32'(bus.mem_dst_addr), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_pop_a_out", bus.mem_out, 32'hB);
        check("bp_pop_a_occ", 32'(bus.occupancy), 32'd1);
        check("bp_pop_a_rdy", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_c_out", bus.mem_out, 32'hC);
        check("bp_c_occ", 32'(bus.occupancy), 32'd1);
        bus.in_valid = 1'b0;
        step();
        check_empty("bp_drain");

        // Misaligned access: keep pc/en/br_flag, neutralise the rest, raise code 4.
        bus.out_ready     = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_pc         = 30'h10;
        bus.in_en         = 1'b1;
        bus.in_br_flag    = 1'b1;
        bus.in_ctrl_op    = 2'd2;
        bus.in_dst_addr   = 5'd7;
        bus.in_gpr_we_    = 1'b0;
        bus.in_exp_code   = 3'd0;
        bus.in_out        = 32'hDEADBEEF;
        bus.in_miss_align = 1'b1;
        step();
        check("ma_pc", 32'(bus.mem_pc), 32'h10);
        check("ma_en", 32'(bus.mem_en), 32'd1);
        check("ma_br", 32'(bus.mem_br_flag), 32'd1);
        check("ma_ctrl", 32'(bus.mem_ctrl_op), 32'd0);
        check("ma_dst", 32'(bus.mem_dst_addr), 32'd0);
        check("ma_we", 32'(bus.mem_gpr_we_), 32'd1);
        check("ma_exp", 32'(bus.mem_exp_code), 32'd4);
        check("ma_out", bus.mem_out, 32'd0);
        drive(1'b0, 30'd0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        step();
        check_empty("ma_drain");

        // Flush at occupancy 2 with a new input present: everything is dropped.
        bus.out_ready = 1'b0;
        drive(1'b1, 30'h4, 5'd4, 32'h111);
        step();
        drive(1'b1, 30'h5, 5'd5, 32'h222);
        step();
        check("fl_pre_occ", 32'(bus.occupancy), 32'd2);
        flush = 1'b1;
        drive(1'b1, 30'h6, 5'd6, 32'h333);
        step();
        flush = 1'b0;
        check_empty("flush");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("fl_after_valid", 32'(bus.out_valid), 32'd0);
        check("fl_after_out", bus.mem_out, 32'd0);

        // Push and pop together while holding one entry.
        bus.out_ready = 1'b0;
        drive(1'b1, 30'h7, 5'd8, 32'hD);
        step();
        check("pp_d_out", bus.mem_out, 32'hD);
        bus.out_ready = 1'b1;
        drive(1'b1, 30'h8, 5'd9, 32'hE);
        step();
        check("pp_e_occ", 32'(bus.occupancy), 32'd1);
        check("pp_e_out", bus.mem_out, 32'hE);
        check("pp_e_pc", 32'(bus.mem_pc), 32'h8);

        // Asynchronous reset mid-stream at occupancy 2, then an immediate push.
        bus.out_ready = 1'b0;
        drive(1'b1, 30'h9, 5'd10, 32'hF0);
        step();
        drive(1'b1, 30'hA, 5'd11, 32'hF1);
        step();
        check("rst_pre_occ", 32'(bus.occupancy), 32'd2);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_empty("async_reset");
        reset = 1'b0;
        drive(1'b1, 30'hB, 5'd12, 32'hF2);
        step();
        check("rst_push_occ", 32'(bus.occupancy), 32'd1);
        check("rst_push_out", bus.mem_out, 32'hF2);
        bus.in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM/WB pipeline register for the next-generation core, sitting between the memory-access unit and the write-back stage. It carries the same per-instruction fields as the current MEM/WB register: PC, valid, branch flag, control op, destination register, GPR write-enable (active-low), exception code and memory result. It replaces the global stall input with a valid/ready handshake backed by a two-entry skid buffer, so write-back back-pressure is absorbed without a combinational ready path. It also keeps synchronous flush and the misaligned-access exception override.

## Interface
- DATA_W, 32, width of memory result
- PC_W, 30, word-address PC width
- REG_ADDR_W, 5, destination register address width
- CTRL_OP_W, 2, control-op width; value 0 is NOP
- EXP_W, 3, exception-code width; value 0 is no-exception
- MISS_ALIGN_CODE, 4, exception code written on misaligned access
---
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_pc  in  PC_W  instruction PC
- in_en  in  1  instruction-valid flag
- in_br_flag  in  1  delay-slot/branch flag
- in_ctrl_op  in  CTRL_OP_W  control op
- in_dst_addr  in  REG_ADDR_W  destination register
- in_gpr_we_  in  1  GPR write enable, active-low
- in_exp_code  in  EXP_W  upstream exception code
- in_out  in  DATA_W  memory/ALU result
- in_miss_align  in  1  misaligned access detected for this entry
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back accepts head
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  (matching in_* widths)  head-entry fields
- occupancy  out  2  entries held (0..2)

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Capture transform: if in_miss_align=1, store pc/en/br_flag unchanged, ctrl_op=0, dst_addr=0, gpr_we_=1, exp_code=MISS_ALIGN_CODE, out=0. Otherwise store the fields verbatim.
- Bubble value: pc=0, en=0, br_flag=0, ctrl_op=0, dst_addr=0, gpr_we_=1, exp_code=0, out=0.
- State machine (tracked by occupancy):
  - EMPTY: push -> ONE. Entry goes to main.
  - ONE: push & pop -> ONE, main replaced by the new entry. Push only -> TWO, new entry goes to skid. Pop only -> EMPTY, main set to bubble.
  - TWO: in_ready=0. Pop -> ONE, skid moves to main and skid set to bubble.
- mem_* always reflect main. They show the bubble value whenever out_valid=0.
- in_ready is registered: next value = (next state != TWO).
- Flush has priority over push and pop. The next state is EMPTY, both entries are set to bubble, and in_ready becomes 1. An input presented in the flush cycle is dropped. A head popped in the flush cycle counts as delivered.
- Head stability: while out_valid=1 & out_ready=0, all mem_* hold constant.

## Timing
- Reset (asynchronous, immediate): out_valid=0, in_ready=1, occupancy=0, all mem_* at bubble value.
- Latency: entry accepted at edge N appears on mem_* / out_valid after edge N.
- Throughput: 1 entry/cycle with out_ready held high; the skid stays unused.
- One stall cycle (out_ready=0 for one cycle with in_valid=1) moves the stage to TWO. in_ready drops after that edge and rises again one cycle after the next pop.
- No combinational path from out_ready to in_ready.
- Reset asserted mid-stream discards every held entry. The first push after reset deasserts is accepted on the first edge.

## Test plan
- Reset: assert reset with occupancy=2 -> immediately out_valid=0, in_ready=1, mem_gpr_we_=1, mem_exp_code=0, mem_out=0.
- Streaming: 8 entries (in_out=0x100+i, dst=i), out_ready=1 -> out_valid one cycle after each push, order preserved, occupancy never exceeds 1.
- Back-pressure: push A, B while out_ready=0 -> occupancy=2 and in_ready=0. C is held off. Raise out_ready -> A, B, C delivered in order, no loss or duplication.
- Miss-align: push pc=0x10, en=1, ctrl_op=2, dst=7, gpr_we_=0, exp=0, out=0xDEADBEEF, in_miss_align=1 -> mem_pc=0x10, en=1, ctrl_op=0, dst=0, gpr_we_=1, exp_code=4, out=0.
- Flush: flush at occupancy=2 with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1. The flushed-cycle input is never delivered.
- Simultaneous events in ONE: push & pop in the same cycle -> occupancy stays 1 and mem_* show the new entry.
